// File: rtl/teclado_fifo_reg.sv
// Keyboard scancode FIFO with a 32-bit status/data word for the processor.
// Holds up to DEPTH scancodes so fast typing is not lost between processor reads.
module teclado_fifo_reg #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE_Teclado,
  input  logic [DATA_W-1:0] KEY_IN,
  input  logic              RD_Procesador,
  input  logic              WE_Procesador,
  input  logic [31:0]       IN,
  output logic [31:0]       OUT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic empty;
  logic full;
  logic flush;
  logic clr_ovf;
  logic do_pop;
  logic do_push;
  logic ovf_set;
  logic unused_in;

  assign unused_in = ^IN[31:2];

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign flush   = WE_Procesador & IN[0];
  assign clr_ovf = WE_Procesador & IN[1];

  // A flush discards any same-cycle keyboard or processor traffic; a pop frees the slot for a push when full.
  assign do_pop  = RD_Procesador & ~empty & ~flush;
  assign do_push = WE_Teclado & (~full | do_pop) & ~flush;
  assign ovf_set = WE_Teclado & full & ~do_pop & ~flush;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= KEY_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Setting overflow wins over a same-cycle clear request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    OUT        = '0;
    OUT[31]    = ~empty;
    OUT[30]    = overflow;
    OUT[29:24] = 6'(count);
    if (!empty) begin
      OUT[DATA_W-1:0] = mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_teclado_fifo_reg.sv
// Self-checking bench for teclado_fifo_reg with a queue scoreboard of expected scancodes.
// Each scenario task drives the FIFO and compares OUT against the scoreboard and fixed words.
module tb_teclado_fifo_reg;

  logic        CLK;
  logic        RESET;
  logic        WE_Teclado;
  logic [7:0]  KEY_IN;
  logic        RD_Procesador;
  logic        WE_Procesador;
  logic [31:0] IN;
  logic [31:0] OUT;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf;

  teclado_fifo_reg #(.DATA_W(8), .DEPTH(8)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .WE_Teclado(WE_Teclado),
    .KEY_IN(KEY_IN),
    .RD_Procesador(RD_Procesador),
    .WE_Procesador(WE_Procesador),
    .IN(IN),
    .OUT(OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    w[30] = exp_ovf;
    w[29:24] = 6'(exp_q.size());
    if (exp_q.size() != 0) begin
      w[31]  = 1'b1;
      w[7:0] = exp_q[0];
    end
    return w;
  endfunction

  // Drive one clock cycle of stimulus and advance the scoreboard the way the FIFO should.
  task automatic cycle(input logic we, input logic [7:0] key, input logic rd,
                       input logic wep, input logic [31:0] in_w, input logic rst);
    bit pop_ok;
    bit push_ok;
    bit set_ovf;
    WE_Teclado = we; KEY_IN = key; RD_Procesador = rd;
    WE_Procesador = wep; IN = in_w; RESET = rst;
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (wep && in_w[0]) begin
      exp_q.delete();
      if (in_w[1]) exp_ovf = 1'b0;
    end else begin
      pop_ok  = rd && (exp_q.size() > 0);
      push_ok = we && ((exp_q.size() < 8) || pop_ok);
      set_ovf = we && !push_ok;
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(key);
      if (wep && in_w[1]) exp_ovf = 1'b0;
      if (set_ovf) exp_ovf = 1'b1;
    end
    @(posedge CLK);
    #1;
    WE_Teclado = 1'b0; RD_Procesador = 1'b0; WE_Procesador = 1'b0;
    IN = '0; RESET = 1'b0;
  endtask

  task automatic test_reset();
    cycle(0, 8'h00, 0, 0, 32'h0, 1);
    checks++;
    if (OUT !== 32'h0000_0000) begin
      errors++; $display("[TB] FAIL reset_out: got %h expected %h", OUT, 32'h0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 0, 32'h0, 0);
    checks++;
    if (OUT !== 32'h0000_0000) begin
      errors++; $display("[TB] FAIL reset_idle: got %h expected %h", OUT, 32'h0);
    end
  endtask

  task automatic test_basic();
    logic [31:0] want [3];
    want[0] = 32'h8200_0032; want[1] = 32'h8100_0021; want[2] = 32'h0000_0000;
    cycle(1, 8'h1C, 0, 0, 32'h0, 0);
    cycle(1, 8'h32, 0, 0, 32'h0, 0);
    cycle(1, 8'h21, 0, 0, 32'h0, 0);
    checks++;
    if (OUT !== 32'h8300_001C) begin
      errors++; $display("[TB] FAIL basic_push3: got %h expected %h", OUT, 32'h8300_001C);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 1, 0, 32'h0, 0);
      checks++;
      if (OUT !== want[i] || OUT !== model_word()) begin
        errors++; $display("[TB] FAIL basic_pop%0d: got %h expected %h", i, OUT, want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 0, 32'h0, 0);
    cycle(1, 8'hFF, 0, 0, 32'h0, 0);
    checks++;
    if (OUT !== 32'hC800_0001) begin
      errors++; $display("[TB] FAIL ovf_set: got %h expected %h", OUT, 32'hC800_0001);
    end
    cycle(0, 8'h00, 0, 1, 32'h2, 0);
    checks++;
    if (OUT !== 32'h8800_0001) begin
      errors++; $display("[TB] FAIL ovf_clear: got %h expected %h", OUT, 32'h8800_0001);
    end
    cycle(1, 8'hEE, 0, 1, 32'h2, 0);
    checks++;
    if (OUT !== 32'hC800_0001) begin
      errors++; $display("[TB] FAIL ovf_set_beats_clear: got %h expected %h", OUT, 32'hC800_0001);
    end
    cycle(0, 8'h00, 0, 1, 32'hFFFF_FFF2, 0);
    for (int i = 0; i < 20 && OUT[31]; i++) begin
      want = model_word();
      checks++;
      if (OUT !== want || OUT[7:0] === 8'hFF || OUT[7:0] === 8'hEE) begin
        errors++; $display("[TB] FAIL ovf_drain%0d: got %h expected %h", i, OUT, want);
      end
      cycle(0, 8'h00, 1, 0, 32'h0, 0);
    end
    checks++;
    if (OUT !== 32'h0) begin
      errors++; $display("[TB] FAIL ovf_empty: got %h expected %h", OUT, 32'h0);
    end
  endtask

  task automatic test_full_simul_wrap();
    logic [7:0]  last;
    logic [31:0] want;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) cycle(1, 8'($urandom_range(0, 8'hA9)), 0, 0, 32'h0, 0);
      cycle(1, 8'hAA, 1, 0, 32'h0, 0);
      checks++;
      if (OUT[30:24] !== 7'h08 || OUT !== model_word()) begin
        errors++; $display("[TB] FAIL full_simul%0d: got %h expected %h", r, OUT, model_word());
      end
      last = 8'h00;
      for (int i = 0; i < 20 && OUT[31]; i++) begin
        want = model_word();
        checks++;
        if (OUT !== want) begin
          errors++; $display("[TB] FAIL wrap_drain%0d_%0d: got %h expected %h", r, i, OUT, want);
        end
        last = OUT[7:0];
        cycle(0, 8'h00, 1, 0, 32'h0, 0);
      end
      checks++;
      if (last !== 8'hAA || OUT !== 32'h0) begin
        errors++; $display("[TB] FAIL wrap_last%0d: got %h/%h expected aa/00000000", r, last, OUT);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0, 32'h0, 0);
    cycle(1, 8'h55, 1, 1, 32'h1, 0);
    checks++;
    if (OUT !== 32'h0) begin
      errors++; $display("[TB] FAIL flush_out: got %h expected %h", OUT, 32'h0);
    end
    cycle(1, 8'h66, 0, 0, 32'h0, 0);
    checks++;
    if (OUT !== 32'h8100_0066) begin
      errors++; $display("[TB] FAIL flush_after_push: got %h expected %h", OUT, 32'h8100_0066);
    end
    cycle(0, 8'h00, 1, 0, 32'h0, 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h10 + i), 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'(8'h20 + i), 0, 0, 32'h0, 0);
      cycle(0, 8'h00, 1, 0, 32'h0, 0);
    end
    checks++;
    if (OUT !== model_word() || OUT[29:24] !== 6'd4) begin
      errors++; $display("[TB] FAIL burst_state: got %h expected %h", OUT, model_word());
    end
    cycle(1, 8'h99, 1, 0, 32'h0, 1);
    checks++;
    if (OUT !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_out: got %h expected %h", OUT, 32'h0);
    end
    cycle(1, 8'h77, 0, 0, 32'h0, 0);
    checks++;
    if (OUT !== 32'h8100_0077) begin
      errors++; $display("[TB] FAIL midreset_push: got %h expected %h", OUT, 32'h8100_0077);
    end
  endtask

  initial begin
    RESET = 1'b1; WE_Teclado = 1'b0; KEY_IN = '0; RD_Procesador = 1'b0;
    WE_Procesador = 1'b0; IN = '0; exp_ovf = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul_wrap();
    test_flush();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
